// File: rtl/sr_flop_sequencer_pkg.sv
// Shared types and helpers for the set/clear flop-bank sequencer.
package sr_seq_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ASSERT,
        GAP
    } state_e;

    typedef enum logic {
        ACT_SET,
        ACT_CLR
    } action_e;

    // Width of a down-counter that must hold the longer of the pulse and gap lengths
    function automatic int cnt_width(input int pulse_cyc, input int gap_cyc);
        int longest;
        longest = (pulse_cyc > gap_cyc) ? pulse_cyc : gap_cyc;
        return (longest + 1 > 2) ? $clog2(longest + 1) : 1;
    endfunction

endpackage

// File: rtl/sr_flop_sequencer_if.sv
// Requester/flop-bank handshake bundle for the sequencer.
interface sr_flop_sequencer_if #(
    parameter int N_REQ = 4
) ();

    logic [N_REQ-1:0] req_set;
    logic [N_REQ-1:0] req_clr;
    logic [N_REQ-1:0] grant;
    logic             set_o;
    logic             rst_n_o;
    logic             busy;

    modport master (
        output req_set,
        output req_clr,
        input  grant,
        input  set_o,
        input  rst_n_o,
        input  busy
    );

    modport slave (
        input  req_set,
        input  req_clr,
        output grant,
        output set_o,
        output rst_n_o,
        output busy
    );

endinterface

// File: rtl/sr_flop_sequencer_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 upward, wrapping to 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         winner,
    output logic [$clog2(N)-1:0] index,
    output logic                 valid
);

    localparam int IDX_W = $clog2(N);

    // Walk offsets from farthest to nearest so the nearest eligible requester is kept
    always_comb begin
        int cand;
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int off = N; off >= 1; off--) begin
            cand = (int'(ptr) + off) % N;
            if (req[cand]) begin
                winner       = '0;
                winner[cand] = 1'b1;
                index        = IDX_W'(cand);
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_flop_sequencer.sv
// Arbitrates set/clear requests onto one registered, mutually exclusive set/clear pair.
module sr_flop_sequencer
    import sr_seq_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sr_flop_sequencer_if.slave   bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = cnt_width(PULSE_CYC, GAP_CYC);

    state_e             state_q, state_d;
    action_e            act_q, act_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               set_q, set_d;
    logic               rst_n_q, rst_n_d;
    logic               busy_q, busy_d;
    logic               sync_q, sync_d;

    logic [N_REQ-1:0]   win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req    (bus.req_set | bus.req_clr),
        .ptr    (ptr_q),
        .winner (win_onehot),
        .index  (win_idx),
        .valid  (win_valid)
    );

    // First synchroniser stage for reset release; the INIT exit flops form the second stage
    always_comb begin
        sync_d = 1'b1;
    end

    // Next-state, counter, pointer and registered output values
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = '0;
        set_d   = set_q;
        rst_n_d = rst_n_q;
        case (state_q)
            INIT: begin
                if (sync_q) begin
                    state_d = IDLE;
                    set_d   = 1'b0;
                    rst_n_d = 1'b1;
                end
            end
            IDLE: begin
                set_d   = 1'b0;
                rst_n_d = 1'b1;
                if (win_valid) begin
                    state_d = ASSERT;
                    grant_d = win_onehot;
                    ptr_d   = win_idx;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    if (bus.req_clr[win_idx]) begin
                        act_d   = ACT_CLR;
                        set_d   = 1'b0;
                        rst_n_d = 1'b0;
                    end else begin
                        act_d   = ACT_SET;
                        set_d   = 1'b1;
                        rst_n_d = 1'b1;
                    end
                end
            end
            ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                    set_d   = 1'b0;
                    rst_n_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    set_d   = (act_q == ACT_SET);
                    rst_n_d = (act_q == ACT_SET);
                end
            end
            GAP: begin
                set_d   = 1'b0;
                rst_n_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset forces the bank clear asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 1'b0;
            state_q <= INIT;
            act_q   <= ACT_CLR;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            grant_q <= '0;
            set_q   <= 1'b0;
            rst_n_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            set_q   <= set_d;
            rst_n_q <= rst_n_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.set_o   = set_q;
    assign bus.rst_n_o = rst_n_q;
    assign bus.busy    = busy_q;

endmodule
